// File: rtl/onehot_decoder_queue.sv
// ADDR_W -> 2**ADDR_W one-hot decoder behind a DEPTH-entry valid/ready FIFO.
// Decoding happens at push time, so stored select vectors stay stable until they are popped.
module onehot_decoder_queue #(
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic                       in_enable,
  input  logic                       in_bcast,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(1<<ADDR_W)-1:0]     out_decoded,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int OUT_W = 1 << ADDR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OUT_W-1:0]  vec;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           ent;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign out_valid = (cnt_q != '0);
  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt_q;

  // Disabled requests store a clean zero entry so X on addr/bcast never lands in the queue.
  always_comb begin
    ent = '0;
    if (in_enable) begin
      ent.addr = in_addr;
      ent.vec  = in_bcast ? '1 : (OUT_W'(1) << in_addr);
    end
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      unique case (1'b1)
        push & ~pop: cnt_d = cnt_q + CNT_W'(1);
        pop & ~push: cnt_d = cnt_q - CNT_W'(1);
        default:     cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
    end else if (push && !flush) begin
      mem_q[wr_q] <= ent;
    end
  end

  // Empty queue presents zeros rather than whatever the head slot last held.
  assign out_decoded = out_valid ? mem_q[rd_q].vec  : '0;
  assign out_addr    = out_valid ? mem_q[rd_q].addr : '0;

endmodule
